code_converter_ctrl: RTL and testbench

Control FSM for the bit-serial binary/Gray code-converter datapath. It accepts a conversion request on a start/done handshake and sequences the datapath's strobes: operand load, MSB copy, then seven fetch/XOR-write bit steps from bit 6 down to bit 0. It latches the conversion mode and monitors the datapath counter for protocol errors. It sits directly upstream of the datapath and drives every one of its control inputs.

---
 rtl/code_converter_pkg.sv | 7 +
 rtl/code_converter_ctrl.sv | 55 +++++
 tb/tb_code_converter_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/code_converter_pkg.sv
// code_converter_pkg: shared state encoding and constants for the Gray/binary converter control
package code_converter_pkg;
  typedef enum logic [2:0] {IDLE, MSB, FETCH, WRITE, DONE} state_t;
  localparam logic MODE_BIN2GRAY = 1'b0;
  localparam logic MODE_GRAY2BIN = 1'b1;
  localparam logic [2:0] MSB_IDX = 3'd7;
endpackage

// File: rtl/code_converter_ctrl.sv
// code_converter_ctrl: sequences the bit-serial binary/Gray datapath and flags counter protocol errors
module code_converter_ctrl
  import code_converter_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic mode,
  input  logic cnt_zero,
  output logic busy,
  output logic done,
  output logic err,
  output logic cnt_load,
  output logic cnt_dec,
  output logic msb_copy,
  output logic convert,
  output logic R1_in,
  output logic R2_in,
  output logic R3_in,
  output logic R4_in
);
  state_t state;
  logic [2:0] shadow;
  logic accept;
  logic shadow_zero;
  assign accept      = reset_n && state == IDLE && start;
  assign shadow_zero = shadow == 3'd0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= IDLE;
      convert <= MODE_BIN2GRAY;
    end else begin
      state   <= state == IDLE  ? (start ? MSB : IDLE) :
                 state == MSB   ? FETCH :
                 state == FETCH ? WRITE :
                 state == WRITE ? (shadow_zero ? DONE : FETCH) : IDLE;
      convert <= accept ? mode : convert;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) shadow <= 3'd0;
    else shadow <= accept ? MSB_IDX :
                   (state == MSB || (state == WRITE && !shadow_zero)) ? shadow - 3'd1 : shadow;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) err <= 1'b0;
    else err <= accept ? 1'b0 : (state == WRITE && cnt_zero != shadow_zero) ? 1'b1 : err;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign R1_in    = accept;
  assign cnt_load = accept;
  assign msb_copy = state == MSB;
  assign R2_in    = state == MSB || state == WRITE;
  assign cnt_dec  = state == MSB || (state == WRITE && !shadow_zero);
  assign R3_in    = state == FETCH;
  assign R4_in    = state == FETCH;
endmodule

// File: tb/tb_code_converter_ctrl.sv
// tb_code_converter_ctrl: drives the control FSM against a datapath model and an arithmetic conversion reference
module tb_code_converter_ctrl;
  import code_converter_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic inject = 1'b0;
  logic cnt_zero;
  logic busy, done, err, cnt_load, cnt_dec, msb_copy, convert, R1_in, R2_in, R3_in, R4_in;
  logic [7:0] bus_in = 8'h00;
  logic [7:0] r1, r2;
  logic r3, r4;
  logic [2:0] cnt = 3'd0;
  logic [8:0] obs;
  int checks = 0;
  int errors = 0;

  code_converter_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .cnt_zero(cnt_zero),
    .busy(busy), .done(done), .err(err), .cnt_load(cnt_load), .cnt_dec(cnt_dec),
    .msb_copy(msb_copy), .convert(convert), .R1_in(R1_in), .R2_in(R2_in),
    .R3_in(R3_in), .R4_in(R4_in)
  );

  always #5 clk = ~clk;

  assign obs      = {cnt_load, cnt_dec, msb_copy, R1_in, R2_in, R3_in, R4_in, busy, done};
  assign cnt_zero = inject | (cnt == 3'd0);

  always @(posedge clk) begin
    if (R1_in) r1 <= bus_in;
    if (cnt_load) cnt <= 3'd7;
    else if (cnt_dec) cnt <= cnt - 3'd1;
    if (msb_copy && R2_in) r2[7] <= r1[7];
    else if (R2_in) r2[cnt] <= r3 ^ r4;
    if (R3_in) r3 <= convert ? r2[3'(cnt + 3'd1)] : r1[3'(cnt + 3'd1)];
    if (R4_in) r4 <= r1[cnt];
  end

  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b = g;
    for (int s = 1; s < 8; s++) b ^= g >> s;
    return b;
  endfunction

  function automatic logic [8:0] exp_vec(input int k);
    return k == 0  ? 9'b100100000 :
           k == 1  ? 9'b011010010 :
           k == 16 ? 9'b000000011 :
           k % 2 == 0 ? 9'b000001110 :
           {1'b0, k != 15, 7'b0010010};
  endfunction

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic run(input logic [7:0] din, input logic m, input bit hold, input bit inj);
    logic [7:0] ref_v;
    int decs;
    ref_v = m ? g2b(din) : din ^ (din >> 1);
    decs = 0;
    @(posedge clk);
    #1;
    bus_in = din;
    mode   = m;
    start  = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("strobes k=%0d in=%h", k, din), obs, exp_vec(k));
      decs += int'(cnt_dec);
      if (k >= 1) chk($sformatf("convert k=%0d", k), convert, m);
      if (k == 1) begin
        chk("err_clear_on_accept", err, 1'b0);
        start  = hold;
        mode   = 1'($urandom_range(0, 1));
        bus_in = 8'($urandom);
      end
      if (k == 16) begin
        chk($sformatf("result in=%h mode=%0d", din, m), r2, ref_v);
        chk("err_at_done", err, inj);
        chk("cnt_dec_total", 16'(decs), 16'd7);
      end
      inject = inj && (k == 2 || k == 3);
    end
    if (!hold) begin
      @(negedge clk);
      chk("idle_busy", {busy, done}, 2'b00);
      chk("err_sticky", err, inj);
    end
  endtask

  initial begin
    mode  = MODE_GRAY2BIN;
    start = 1'b1;
    #3;
    chk("reset_strobes", obs, 9'd0);
    chk("reset_err", err, 1'b0);
    chk("reset_convert", convert, 1'b0);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run(8'hB6, MODE_BIN2GRAY, 0, 0);
    run(8'hFF, MODE_BIN2GRAY, 0, 0);
    run(8'h00, MODE_BIN2GRAY, 0, 0);
    run(8'hED, MODE_GRAY2BIN, 0, 0);
    run(8'h3C, MODE_BIN2GRAY, 1, 0);
    run(8'hA5, MODE_GRAY2BIN, 0, 0);
    @(posedge clk);
    #1;
    bus_in = 8'hC3;
    mode   = MODE_GRAY2BIN;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midop_reset_strobes", obs, 9'd0);
    chk("midop_reset_convert", convert, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    run(8'h5A, MODE_BIN2GRAY, 0, 0);
    chk("run_5a_value", r2, 8'h77);
    run(8'h96, MODE_BIN2GRAY, 0, 1);
    run(8'h4E, MODE_GRAY2BIN, 0, 0);
    for (int i = 0; i < 6; i++) run(8'($urandom), 1'($urandom_range(0, 1)), 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
